// File: rtl/mem_msg_pkg.sv
`default_nettype none
// ============================================================================
// mem_msg_pkg
// Shared memory message widths, arbiter state encoding and round-robin pick.
// Revision: 1.0
// ============================================================================
package mem_msg_pkg;

  localparam int unsigned REQ_NBITS  = 78;
  localparam int unsigned RESP_NBITS = 35;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  // A lone requester always wins; contention is settled by the priority bit.
  function automatic logic arb_pick(input logic v0, input logic v1, input logic prio);
    return (v0 && v1) ? prio : v1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/Mux2_RTL.sv
`default_nettype none
// ============================================================================
// Mux2_RTL
// Generic two-input multiplexer, sel_i=1 selects in1_i.
// Revision: 1.0
// ============================================================================
module Mux2_RTL #(
  parameter int unsigned p_nbits = 1
) (
  input  logic [p_nbits-1:0] in0_i,
  input  logic [p_nbits-1:0] in1_i,
  input  logic               sel_i,
  output logic [p_nbits-1:0] out_o
);

  assign out_o = sel_i ? in1_i : in0_i;

endmodule
`default_nettype wire

// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// mem_req_arbiter
// Round-robin arbiter sharing one memory port between two requesters,
// one outstanding transaction at a time.
// Revision: 1.0
// ============================================================================
module mem_req_arbiter
  import mem_msg_pkg::*;
#(
  parameter int unsigned p_req_nbits  = REQ_NBITS,
  parameter int unsigned p_resp_nbits = RESP_NBITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0_val,
  output logic                    req0_rdy,
  input  logic [p_req_nbits-1:0]  req0_msg,
  input  logic                    req1_val,
  output logic                    req1_rdy,
  input  logic [p_req_nbits-1:0]  req1_msg,
  output logic                    mem_req_val,
  input  logic                    mem_req_rdy,
  output logic [p_req_nbits-1:0]  mem_req_msg,
  input  logic                    mem_resp_val,
  output logic                    mem_resp_rdy,
  input  logic [p_resp_nbits-1:0] mem_resp_msg,
  output logic                    resp0_val,
  input  logic                    resp0_rdy,
  output logic                    resp1_val,
  input  logic                    resp1_rdy,
  output logic [p_resp_nbits-1:0] resp_msg,
  output logic                    grant
);

  arb_state_t state_q, state_d;
  logic       grant_q, grant_d;
  logic       prio_q,  prio_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
    end
  end

  // The grant decision is taken in IDLE and registered, so no ready is ever
  // a combinational function of the incoming valids.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    prio_d       = prio_q;
    req0_rdy     = 1'b0;
    req1_rdy     = 1'b0;
    mem_req_val  = 1'b0;
    mem_resp_rdy = 1'b0;
    resp0_val    = 1'b0;
    resp1_val    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_val || req1_val) begin
          grant_d = arb_pick(req0_val, req1_val, prio_q);
          state_d = SEND;
        end
      end
      SEND: begin
        mem_req_val = 1'b1;
        req0_rdy    = mem_req_rdy & ~grant_q;
        req1_rdy    = mem_req_rdy &  grant_q;
        if (mem_req_rdy) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        mem_resp_rdy = grant_q ? resp1_rdy : resp0_rdy;
        resp0_val    = mem_resp_val & ~grant_q;
        resp1_val    = mem_resp_val &  grant_q;
        if (mem_resp_val && (grant_q ? resp1_rdy : resp0_rdy)) begin
          state_d = IDLE;
          prio_d  = ~grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  Mux2_RTL #(
    .p_nbits (p_req_nbits)
  ) u_req_mux (
    .in0_i (req0_msg),
    .in1_i (req1_msg),
    .sel_i (grant_q),
    .out_o (mem_req_msg)
  );

  assign resp_msg = mem_resp_msg;
  assign grant    = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_req_arbiter
// Scoreboard bench: randomized requesters, memory and sinks around the arbiter.
// Revision: 1.0
// ============================================================================
module tb_mem_req_arbiter;
  import mem_msg_pkg::*;

  localparam int RQ = 78;
  localparam int RS = 35;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0_val = 1'b0, req1_val = 1'b0;
  logic [RQ-1:0] req0_msg = '0,   req1_msg = '0;
  logic          req0_rdy, req1_rdy, mem_req_val, mem_resp_rdy, resp0_val, resp1_val, grant;
  logic          mem_req_rdy = 1'b0, mem_resp_val = 1'b0, resp0_rdy = 1'b0, resp1_rdy = 1'b0;
  logic [RQ-1:0] mem_req_msg;
  logic [RS-1:0] mem_resp_msg = '0;
  logic [RS-1:0] resp_msg;

  always #5 clk = ~clk;

  mem_req_arbiter #(.p_req_nbits(RQ), .p_resp_nbits(RS)) dut (
    .clk(clk), .rst(rst),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_msg(mem_req_msg),
    .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_msg(mem_resp_msg),
    .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
    .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
    .resp_msg(resp_msg), .grant(grant)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // The memory answers with a fixed function of the request it accepted.
  function automatic logic [RS-1:0] resp_of(input logic [RQ-1:0] m);
    return {3'b001, m[31:0] ^ 32'hDEAD_BE45};
  endfunction

  // Environment knobs (written by the main sequence only)
  int p_mem_rdy = 100, p_r0 = 100, p_r1 = 100, mem_dly_max = 0;
  bit junk_en = 1'b0, gap_en = 1'b0;

  logic [RQ-1:0] src0_q[$], src1_q[$];
  logic          f_req0 = 0, f_req1 = 0, f_mreq = 0, f_mresp = 0;
  logic [RQ-1:0] cap_mreq_msg = '0;

  typedef struct {
    logic          port;
    logic [RQ-1:0] msg;
    logic [RS-1:0] resp;
    int            dcyc;
  } txn_t;
  txn_t exp_q[$];
  bit   just_done   = 1'b0;
  logic last_served = 1'b1;

  logic          log_port[$];
  int            log_cyc[$];
  logic [RS-1:0] log_resp[$];

  // ---------------- requesters: hold val/msg until the transfer fires
  always @(negedge clk) begin : drv_req
    if (!rst) begin
      req0_val = 1'b0; req1_val = 1'b0;
      src0_q.delete(); src1_q.delete();
    end else begin
      if (f_req0) void'(src0_q.pop_front());
      if (f_req1) void'(src1_q.pop_front());
      if (!req0_val || f_req0)
        req0_val = (src0_q.size() > 0) && (!gap_en || $urandom_range(3) != 0);
      if (!req1_val || f_req1)
        req1_val = (src1_q.size() > 0) && (!gap_en || $urandom_range(3) != 0);
      if (req0_val) req0_msg = src0_q[0];
      if (req1_val) req1_msg = src1_q[0];
    end
  end

  // ---------------- memory: one pending request, random latency, junk responses
  logic          mem_pend = 1'b0;
  int            mem_dly  = 0;
  logic [RQ-1:0] mem_pend_msg = '0;
  always @(negedge clk) begin : drv_mem
    if (!rst) begin
      mem_pend = 1'b0; mem_resp_val = 1'b0; mem_req_rdy = 1'b0;
      resp0_rdy = 1'b0; resp1_rdy = 1'b0;
    end else begin
      if (f_mresp) mem_pend = 1'b0;
      if (f_mreq) begin
        mem_pend = 1'b1; mem_pend_msg = cap_mreq_msg;
        mem_dly  = $urandom_range(mem_dly_max);
      end
      mem_req_rdy = ($urandom_range(99) < p_mem_rdy);
      resp0_rdy   = ($urandom_range(99) < p_r0);
      resp1_rdy   = ($urandom_range(99) < p_r1);
      if (mem_pend) begin
        if (mem_dly == 0) begin
          mem_resp_val = 1'b1; mem_resp_msg = resp_of(mem_pend_msg);
        end else begin
          mem_dly--; mem_resp_val = 1'b0;
        end
      end else begin
        mem_resp_val = junk_en && ($urandom_range(3) == 0);
        mem_resp_msg = RS'($urandom());
      end
    end
  end

  // ---------------- reference model: who should be served next
  logic prev_stall = 1'b0, prev_g = 1'b0;
  always @(negedge clk) begin : model
    txn_t t;
    #2;
    if (!rst) begin
      last_served = 1'b1; just_done = 1'b0; prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        assert (prev_g ? req1_val : req0_val)
          else $error("FAIL val_drop: granted requester dropped val before transfer");
      prev_stall = mem_req_val && !mem_req_rdy;
      prev_g     = grant;
      if (just_done) just_done = 1'b0;
      else if (exp_q.size() == 0 && (req0_val || req1_val)) begin
        t.port      = (req0_val && req1_val) ? ~last_served : req1_val;
        t.msg       = t.port ? req1_msg : req0_msg;
        t.resp      = resp_of(t.msg);
        t.dcyc      = cyc;
        last_served = t.port;
        exp_q.push_back(t);
      end
    end
  end

  always @(negedge clk) begin : xcheck
    #1;
    if (rst) assert (!$isunknown(grant)) else $error("FAIL grant_x: grant is unknown");
  end

  // ---------------- monitor / scoreboard
  int phase = 0;
  always @(negedge clk) begin : monitor
    txn_t t;
    #1;
    cyc++;
    f_req0       = req0_val && req0_rdy;
    f_req1       = req1_val && req1_rdy;
    f_mreq       = mem_req_val && mem_req_rdy;
    f_mresp      = mem_resp_val && mem_resp_rdy;
    cap_mreq_msg = mem_req_msg;
    if (!rst) begin
      exp_q.delete(); phase = 0;
    end else if (exp_q.size() == 0) begin
      check("idle_quiet", {req0_rdy, req1_rdy, mem_req_val, mem_resp_rdy, resp0_val, resp1_val}, 0);
    end else begin
      t = exp_q[0];
      check("grant", grant, t.port);
      check("loser_req_rdy", t.port ? req0_rdy : req1_rdy, 0);
      check("loser_resp_val", t.port ? resp0_val : resp1_val, 0);
      if (phase == 0) begin
        check("req_latency", cyc - t.dcyc, 1);
        phase = 1;
      end
      if (phase == 1) begin
        check("send_val", mem_req_val, 1);
        check("send_msg", mem_req_msg, t.msg);
        check("win_req_rdy", t.port ? req1_rdy : req0_rdy, mem_req_rdy);
        check("send_resp_quiet", {mem_resp_rdy, resp0_val, resp1_val}, 0);
        if (mem_req_rdy) phase = 2;
      end else begin
        check("wait_req_quiet", {mem_req_val, req0_rdy, req1_rdy}, 0);
        check("wait_resp_rdy", mem_resp_rdy, t.port ? resp1_rdy : resp0_rdy);
        check("wait_resp_val", t.port ? resp1_val : resp0_val, mem_resp_val);
        if (mem_resp_val && (t.port ? resp1_rdy : resp0_rdy)) begin
          check("resp_msg", resp_msg, t.resp);
          log_port.push_back(t.port); log_cyc.push_back(cyc); log_resp.push_back(resp_msg);
          void'(exp_q.pop_front());
          phase     = 0;
          just_done = 1'b1;
        end
      end
    end
  end

  // ---------------- main sequence helpers
  task automatic clear_log();
    log_port.delete(); log_cyc.delete(); log_resp.delete();
  endtask

  task automatic step();
    @(negedge clk); #3;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      step();
      done = (src0_q.size() == 0) && (src1_q.size() == 0) && !req0_val && !req1_val
             && (exp_q.size() == 0);
    end
    check(name, done, 1);
  endtask

  task automatic wait_for_val(input string name, input bit port_resp);
    bit seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      step();
      seen = port_resp ? resp0_val : mem_req_val;
    end
    check(name, seen, 1);
  endtask

  task automatic apply_reset();
    step();
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int start;
    int n0, n1;
    logic [RQ-1:0] m;

    // reset state
    repeat (2) step();
    check("rst_outputs", {req0_rdy, req1_rdy, mem_req_val, mem_resp_rdy, resp0_val, resp1_val, grant}, 0);
    check("rst_mux_sel0", mem_req_msg, req0_msg);
    rst = 1'b1;

    // T1: single request on port 0
    clear_log();
    src0_q.push_back(78'h0_DEAD_BEEF);
    wait_idle("t1_drain", 50);
    check("t1_count", log_port.size(), 1);
    if (log_port.size() == 1) begin
      check("t1_port", log_port[0], 0);
      check("t1_resp", log_resp[0], 35'h1_0000_00AA);
    end

    // T2: both valid right after reset -> 0 then 1, six cycles
    apply_reset();
    clear_log();
    src0_q.push_back(78'h11_2222_3333);
    src1_q.push_back(78'h44_5555_6666);
    start = cyc + 1;
    wait_idle("t2_drain", 50);
    check("t2_count", log_port.size(), 2);
    if (log_port.size() == 2) begin
      check("t2_order", {log_port[0], log_port[1]}, 2'b01);
      check("t2_first_done", log_cyc[0] - start, 2);
      check("t2_total", log_cyc[1] - start, 5);
    end

    // T3: port 1 streams four requests, one per three cycles
    clear_log();
    for (int i = 0; i < 4; i++) src1_q.push_back(RQ'(32'hA000 + i));
    wait_idle("t3_drain", 60);
    check("t3_count", log_port.size(), 4);
    if (log_port.size() == 4)
      for (int i = 0; i < 4; i++) begin
        check("t3_port", log_port[i], 1);
        if (i > 0) check("t3_gap", log_cyc[i] - log_cyc[i-1], 3);
      end

    // T4: memory back-pressure for three cycles in SEND
    clear_log();
    p_mem_rdy = 0;
    m = 78'h3_0BAD_F00D;
    src0_q.push_back(m);
    wait_for_val("t4_send", 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("t4_hold", {mem_req_val, req0_rdy, req1_rdy, grant}, 4'b1000);
      check("t4_msg", mem_req_msg, m);
      step();
    end
    p_mem_rdy = 100;
    wait_idle("t4_drain", 50);
    check("t4_count", log_port.size(), 1);

    // T5: response sink stalls for two cycles
    clear_log();
    p_r0 = 0;
    src0_q.push_back(78'h5_5555_0005);
    wait_for_val("t5_wait", 1'b1);
    for (int i = 0; i < 2; i++) begin
      check("t5_stall", {mem_resp_rdy, resp0_val}, 2'b01);
      if (i == 0) step();
    end
    p_r0 = 100;
    wait_idle("t5_drain", 50);
    check("t5_count", log_port.size(), 1);

    // T6: asynchronous reset in WAIT, then both valid -> port 0 first
    p_r0 = 0;
    src0_q.push_back(78'h6_6666_0006);
    wait_for_val("t6_wait", 1'b1);
    rst = 1'b0;
    #1;
    check("t6_async_rst", {req0_rdy, req1_rdy, mem_req_val, mem_resp_rdy, resp0_val, resp1_val, grant}, 0);
    check("t6_mux_sel0", mem_req_msg, req0_msg);
    repeat (2) step();
    p_r0 = 100;
    rst  = 1'b1;
    clear_log();
    src0_q.push_back(78'h7_0000_0070);
    src1_q.push_back(78'h7_0000_0071);
    wait_idle("t6_drain", 50);
    check("t6_count", log_port.size(), 2);
    if (log_port.size() == 2) check("t6_order", {log_port[0], log_port[1]}, 2'b01);

    // Random traffic with back-pressure, stalls, gaps and stray responses
    clear_log();
    p_mem_rdy = 70; p_r0 = 75; p_r1 = 60; mem_dly_max = 3;
    junk_en = 1'b1; gap_en = 1'b1;
    n0 = 0; n1 = 0;
    for (int c = 0; c < 600; c++) begin
      if (src0_q.size() < 3 && $urandom_range(2) == 0) begin
        src0_q.push_back(RQ'({$urandom(), $urandom(), $urandom()})); n0++;
      end
      if (src1_q.size() < 3 && $urandom_range(2) == 0) begin
        src1_q.push_back(RQ'({$urandom(), $urandom(), $urandom()})); n1++;
      end
      step();
    end
    wait_idle("rand_drain", 4000);
    begin
      int s0, s1;
      s0 = 0; s1 = 0;
      foreach (log_port[i]) if (log_port[i]) s1++; else s0++;
      check("rand_served0", s0, n0);
      check("rand_served1", s1, n1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
